uart_rx_deserializer: RTL and testbench

- UART receiver. The receive-side counterpart of the transmitter's load/shift serializer.
- Oversamples the serial line RX_IN on a SAMPLE_EN tick that runs at OVERSAMPLE × baud.
- Detects the start bit, majority-votes each bit and shifts data in LSB first, then checks the optional parity bit and the stop bit.
- Presents the assembled byte with a one-cycle valid pulse to the host-side logic.

---
 rtl/uart_rx_deserializer_if.sv | 27 ++
 rtl/uart_rx_deserializer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Signal bundle between the UART receiver and its surroundings: serial line,
// oversample tick, frame format controls and the received-word outputs.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  SAMPLE_EN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STOP_ERR;
  logic                  BUSY;

  // Driver of the line and format controls; observer of the received word.
  modport master (
    output RX_IN, SAMPLE_EN, PAR_EN, PAR_TYP,
    input  DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, BUSY
  );

  // The receiver itself.
  modport slave (
    input  RX_IN, SAMPLE_EN, PAR_EN, PAR_TYP,
    output DATA_OUT, DATA_VALID, PAR_ERR, STOP_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: 2-flop line sync, 3-sample majority vote, LSB-first
// shift-in, stop check. Define UART_RX_PARITY_EN to build the parity bit check.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic                   CLK,
  input logic                   RST,
  uart_rx_deserializer_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  serr_q, serr_d;
  logic                  perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
`else
  logic                  unused_par_inputs;
  assign unused_par_inputs = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  logic tick, at_vote, at_wrap, vote;

  assign tick    = bus.SAMPLE_EN;
  assign at_vote = tick && (tick_q == TICK_VOTE);
  assign at_wrap = tick && (tick_q == TICK_LAST);
  // Third sample is taken live from the synchronizer on the deciding tick.
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so all of them sample the pre-edge values;
  // blocking assignments would let later lines see already-updated state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      // NOTE: the synchronizer resets to the idle line level (1), not 0, so a
      // reset release never looks like a start bit.
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      serr_q    <= 1'b0;
      perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= bus.RX_IN;
      rx_s_q    <= rx_meta_q;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      serr_q    <= serr_d;
      perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        IDLE:  if (!rx_s_q) state_d = START;
        START: begin
          if (at_vote && vote) state_d = IDLE;
          else if (at_wrap)    state_d = DATA;
        end
        DATA: begin
          if (at_wrap && (bit_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (at_wrap) state_d = STOP;
`endif
        STOP:    if (at_vote) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, sampling, shift register and frame evaluation
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_d    = tick_q;
    bit_d     = bit_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    serr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
`endif
    if (tick) begin
      if (state_q == IDLE) begin
        if (!rx_s_q) begin
          tick_d    = '0;
          bit_d     = '0;
`ifdef UART_RX_PARITY_EN
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          par_bad_d = 1'b0;
`endif
        end
      end else begin
        tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
        if (tick_q == TICK_S0) s0_d = rx_s_q;
        if (tick_q == TICK_S1) s1_d = rx_s_q;
        if ((state_q == DATA) && (tick_q == TICK_LAST))
          bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
        if (tick_q == TICK_VOTE) begin
          unique case (state_q)
            DATA: shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_PARITY_EN
            PARITY: par_bad_d = vote ^ (^shift_q) ^ par_typ_q;
`endif
            STOP: begin
              serr_d = ~vote;
`ifdef UART_RX_PARITY_EN
              perr_d = par_en_q & par_bad_q;
`endif
              if (vote && !perr_d) begin
                valid_d = 1'b1;
                dout_d  = shift_q;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.DATA_OUT   = dout_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.STOP_ERR   = serr_q;
  assign bus.BUSY       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.PAR_ERR    = perr_q;
`else
  assign bus.PAR_ERR    = 1'b0;
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are serialized by tasks, the
// expected outcome is queued at send time and matched against each output pulse.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;

  typedef struct packed {
    logic          valid;
    logic          perr;
    logic          serr;
    logic [DW-1:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_good = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_good(input logic [DW-1:0] d);
    exp_t e;
    e.valid = 1'b1; e.perr = 1'b0; e.serr = 1'b0; e.data = d;
    last_good = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic p, input logic s);
    exp_t e;
    e.valid = 1'b0; e.perr = p; e.serr = s; e.data = last_good;
    exp_q.push_back(e);
  endtask

  // One bit period; an optional one-tick-wide inverted spike around mid-bit.
  task automatic drive_bit(input logic v, input bit spike);
    for (int c = 0; c < BIT_CLK; c++) begin
      @(negedge CLK);
      if (spike && (c >= BIT_CLK/2 - TICK_DIV/2) && (c < BIT_CLK/2 + TICK_DIV/2))
        bus.RX_IN = ~v;
      else
        bus.RX_IN = v;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit with_par, input logic par_bit,
                            input logic stop_bit, input int spike_idx);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i], i == spike_idx);
    if (with_par) drive_bit(par_bit, 1'b0);
    drive_bit(stop_bit, 1'b0);
  endtask

  task automatic idle(input int clocks);
    bus.RX_IN = 1'b1;
    repeat (clocks) @(negedge CLK);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 4 * BIT_CLK)) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Oversample tick: one CLK wide, every TICK_DIV clocks.
  initial begin
    bus.SAMPLE_EN = 1'b0;
    forever begin
      for (int i = 0; i < TICK_DIV; i++) begin
        @(negedge CLK);
        bus.SAMPLE_EN = (i == 0);
      end
    end
  end

  // Output monitor: every pulse cycle pops one expectation.
  initial begin
    exp_t          e;
    logic [DW-1:0] prev;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (bus.DATA_VALID || bus.PAR_ERR || bus.STOP_ERR) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {bus.DATA_VALID, bus.PAR_ERR, bus.STOP_ERR}, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_flags", {bus.DATA_VALID, bus.PAR_ERR, bus.STOP_ERR},
                {e.valid, e.perr, e.serr});
          check("data_out", bus.DATA_OUT, e.data);
        end
      end else if (RST && (bus.DATA_OUT !== prev)) begin
        check("data_out_hold", bus.DATA_OUT, prev);
      end
      prev = bus.DATA_OUT;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_data_out",   bus.DATA_OUT,   0);
    check("rst_data_valid", bus.DATA_VALID, 0);
    check("rst_par_err",    bus.PAR_ERR,    0);
    check("rst_stop_err",   bus.STOP_ERR,   0);
    check("rst_busy",       bus.BUSY,       0);
    RST = 1'b1;
    idle(20);

    // Plain frame, no parity.
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    wait_drain("a5");
    check("busy_after_a5", bus.BUSY, 0);
    idle(BIT_CLK);

`ifdef UART_RX_PARITY_EN
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b0;
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    wait_drain("even_par_ok");
    expect_err(1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    wait_drain("even_par_bad");
    bus.PAR_TYP = 1'b1;
    expect_good(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
    wait_drain("odd_par_ok");
`else
    // Parity controls are ignored: no parity bit on the line.
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b1;
    expect_good(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    wait_drain("par_ignored");
`endif
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    idle(BIT_CLK);

    // Framing error, then a good frame.
    expect_err(1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle(2 * BIT_CLK);
    wait_drain("stop_err");
    check("busy_after_stop_err", bus.BUSY, 0);
    expect_good(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1);
    wait_drain("after_stop_err");
    idle(BIT_CLK);

    // Start glitch: low for 3 ticks only.
    bus.RX_IN = 1'b0;
    repeat (3 * TICK_DIV) @(negedge CLK);
    check("glitch_busy_high", bus.BUSY, 1);
    idle(2 * BIT_CLK);
    check("glitch_busy_low", bus.BUSY, 0);
    check("glitch_no_event", exp_q.size(), 0);

    // One-tick spike in data bit 3 is voted out.
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 3);
    wait_drain("spike");
    idle(BIT_CLK);

    // Back-to-back frames with no idle gap.
    expect_good(8'h12);
    expect_good(8'h34);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1);
    wait_drain("back_to_back");
    idle(BIT_CLK);

    // Reset in the middle of data bit 4 of 0xFF.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    repeat (BIT_CLK / 2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_data_out", bus.DATA_OUT,   0);
    check("midrst_busy",     bus.BUSY,       0);
    check("midrst_valid",    bus.DATA_VALID, 0);
    last_good = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle(2 * BIT_CLK);
    check("midrst_no_event", exp_q.size(), 0);
    expect_good(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1);
    wait_drain("after_reset");
    idle(BIT_CLK);
    check("final_busy", bus.BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
